// File: rtl/hpu_pkg.sv
// Shared types and default sizes for the hypervector processing unit readout path.
package hpu_pkg;

    localparam int WORD = 32;
    localparam int DIM  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_SEND  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bundle_reader_word_mux.sv
// Combinational pick of the idx-th WORD-bit slice of the sign-bit snapshot.
module word_mux #(
    parameter int DIM   = 1024,
    parameter int WORD  = 32,
    parameter int IDX_W = 5
) (
    input  logic [DIM-1:0]   snap,
    input  logic [IDX_W-1:0] idx,
    output logic [WORD-1:0]  dat
);

    localparam int NW = DIM / WORD;

    always_comb begin
        dat = '0;
        for (int i = 0; i < NW; i++) begin
            if (idx == IDX_W'(i)) begin
                dat = snap[i*WORD +: WORD];
            end
        end
    end

endmodule

// File: rtl/bundle_reader.sv
// Snapshots DIM counter sign bits after a drain delay and streams them as NW words, then pulses counter_clr and done.
// First word valid DRAIN+1 cycles after start; out_valid/out_data/out_last hold while out_ready is low.
module bundle_reader #(
    parameter int DIM   = hpu_pkg::DIM,
    parameter int WORD  = hpu_pkg::WORD,
    parameter int DRAIN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DIM-1:0]  sign_bits,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] out_data,
    output logic            out_last,
    output logic            busy,
    output logic            counter_clr,
    output logic            done
);

    import hpu_pkg::*;

    localparam int NW     = DIM / WORD;
    localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;
    localparam int DCNT_W = $clog2(DRAIN + 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [DIM-1:0]      snap_q, snap_d;
    logic                last_word;
    logic                drain_end;

    assign last_word = (idx_q == IDX_W'(NW - 1));
    assign drain_end = (dcnt_q == DCNT_W'(DRAIN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dcnt_q  <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_end) state_d = ST_SEND;
            ST_SEND:  if (out_ready && last_word) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Snapshot is taken in the final drain cycle so the store pipeline has settled.
    always_comb begin
        idx_d  = idx_q;
        dcnt_d = dcnt_q;
        snap_d = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) dcnt_d = '0;
            end
            ST_DRAIN: begin
                dcnt_d = dcnt_q + DCNT_W'(1);
                if (drain_end) begin
                    snap_d = sign_bits;
                    idx_d  = '0;
                end
            end
            ST_SEND: begin
                if (out_ready && !last_word) idx_d = idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        out_valid   = (state_q == ST_SEND);
        out_last    = (state_q == ST_SEND) && last_word;
        busy        = (state_q != ST_IDLE);
        counter_clr = (state_q == ST_CLEAR);
        done        = (state_q == ST_DONE);
    end

    word_mux #(
        .DIM   (DIM),
        .WORD  (WORD),
        .IDX_W (IDX_W)
    ) u_word_mux (
        .snap (snap_q),
        .idx  (idx_q),
        .dat  (out_data)
    );

endmodule

// File: tb/tb_bundle_reader.sv
// Directed bench for bundle_reader in a two-word (DIM=64) and a one-word (DIM=32) configuration.
module tb_bundle_reader;

    logic        clk;
    logic        rst;

    logic        start_a, ready_a;
    logic [63:0] sign_a;
    logic        valid_a, last_a, busy_a, clr_a, done_a;
    logic [31:0] data_a;

    logic        start_b, ready_b;
    logic [31:0] sign_b;
    logic        valid_b, last_b, busy_b, clr_b, done_b;
    logic [31:0] data_b;

    int total_cnt = 0;
    int fail_cnt  = 0;
    int hs_a = 0, hs_b = 0, clrs_a = 0, clrs_b = 0;

    logic [32:0] q_a[$];
    logic [32:0] q_b[$];

    bundle_reader #(.DIM(64), .WORD(32), .DRAIN(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .sign_bits(sign_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a), .out_last(last_a),
        .busy(busy_a), .counter_clr(clr_a), .done(done_a)
    );

    bundle_reader #(.DIM(32), .WORD(32), .DRAIN(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .sign_bits(sign_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b), .out_last(last_b),
        .busy(busy_b), .counter_clr(clr_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a(input int budget);
        int n;
        n = 0;
        while (busy_a && n < budget) begin
            tick();
            n++;
        end
        if (busy_a) chk("timeout_idle_a", 64'(busy_a), 64'd0);
    endtask

    // Scoreboard: every handshake pops the next expected {last, data}.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_a && ready_a) begin
                hs_a++;
                if (q_a.size() == 0) chk("a_unexpected_word", {31'd0, last_a, data_a}, 64'd0);
                else chk("a_word", {31'd0, last_a, data_a}, {31'd0, q_a.pop_front()});
            end
            if (valid_b && ready_b) begin
                hs_b++;
                if (q_b.size() == 0) chk("b_unexpected_word", {31'd0, last_b, data_b}, 64'd0);
                else chk("b_word", {31'd0, last_b, data_b}, {31'd0, q_b.pop_front()});
            end
            if (clr_a) clrs_a++;
            if (clr_b) clrs_b++;
        end
    end

    initial begin
        int hs0, clr0;
        rst = 1'b1;
        start_a = 1'b0; ready_a = 1'b0; sign_a = '0;
        start_b = 1'b0; ready_b = 1'b0; sign_b = '0;
        #1;
        chk("reset_valid", 64'(valid_a), 64'd0);
        chk("reset_busy",  64'(busy_a),  64'd0);
        chk("reset_clr",   64'(clr_a),   64'd0);
        chk("reset_done",  64'(done_a),  64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic readout, ready held high
        sign_a = 64'hDEADBEEF_12345678;
        ready_a = 1'b1;
        q_a.push_back({1'b0, 32'h12345678});
        q_a.push_back({1'b1, 32'hDEADBEEF});
        hs0 = hs_a; clr0 = clrs_a;
        start_a = 1'b1;
        tick(); start_a = 1'b0;                       // cycle 1
        chk("basic_busy_c1", 64'(busy_a), 64'd1);
        chk("basic_valid_c1", 64'(valid_a), 64'd0);
        tick(); tick();                               // cycle 3
        chk("basic_valid_c3", 64'(valid_a), 64'd0);
        tick();                                       // cycle 4
        chk("basic_valid_c4", 64'(valid_a), 64'd1);
        chk("basic_data_c4", 64'(data_a), 64'h12345678);
        chk("basic_last_c4", 64'(last_a), 64'd0);
        tick();                                       // cycle 5
        chk("basic_data_c5", 64'(data_a), 64'hDEADBEEF);
        chk("basic_last_c5", 64'(last_a), 64'd1);
        tick();                                       // cycle 6
        chk("basic_clr_c6", 64'(clr_a), 64'd1);
        chk("basic_valid_c6", 64'(valid_a), 64'd0);
        tick();                                       // cycle 7
        chk("basic_done_c7", 64'(done_a), 64'd1);
        chk("basic_clr_c7", 64'(clr_a), 64'd0);
        tick();                                       // cycle 8
        chk("basic_busy_c8", 64'(busy_a), 64'd0);
        chk("basic_done_c8", 64'(done_a), 64'd0);
        chk("basic_words", 64'(hs_a - hs0), 64'd2);
        chk("basic_clr_pulses", 64'(clrs_a - clr0), 64'd1);
        tick();

        // Backpressure: ready low for cycles 4..9
        ready_a = 1'b0;
        q_a.push_back({1'b0, 32'h12345678});
        q_a.push_back({1'b1, 32'hDEADBEEF});
        clr0 = clrs_a;
        start_a = 1'b1;
        tick(); start_a = 1'b0;                       // cycle 1
        tick(); tick(); tick();                       // cycle 4
        for (int c = 4; c <= 9; c++) begin
            chk("bp_valid_hold", 64'(valid_a), 64'd1);
            chk("bp_data_hold", 64'(data_a), 64'h12345678);
            chk("bp_last_hold", 64'(last_a), 64'd0);
            tick();
        end
        ready_a = 1'b1;                               // cycle 10
        chk("bp_data_c10", 64'(data_a), 64'h12345678);
        tick();                                       // cycle 11
        chk("bp_data_c11", 64'(data_a), 64'hDEADBEEF);
        chk("bp_last_c11", 64'(last_a), 64'd1);
        chk("bp_clr_c11", 64'(clr_a), 64'd0);
        tick();                                       // cycle 12
        chk("bp_clr_c12", 64'(clr_a), 64'd1);
        wait_idle_a(10);
        chk("bp_clr_pulses", 64'(clrs_a - clr0), 64'd1);
        tick();

        // Snapshot isolation: input changes after capture are ignored
        sign_a = 64'h01234567_89ABCDEF;
        q_a.push_back({1'b0, 32'h89ABCDEF});
        q_a.push_back({1'b1, 32'h01234567});
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        tick(); tick(); tick();                       // cycle 4
        sign_a = '1;
        chk("snap_data_c4", 64'(data_a), 64'h89ABCDEF);
        tick();                                       // cycle 5
        chk("snap_data_c5", 64'(data_a), 64'h01234567);
        wait_idle_a(10);
        chk("snap_queue_empty", 64'(q_a.size()), 64'd0);
        tick();

        // Start pulses while busy are dropped
        sign_a = 64'hFEDCBA98_76543210;
        q_a.push_back({1'b0, 32'h76543210});
        q_a.push_back({1'b1, 32'hFEDCBA98});
        hs0 = hs_a; clr0 = clrs_a;
        start_a = 1'b1;
        tick(); start_a = 1'b0;                       // cycle 1
        tick(); start_a = 1'b1;                       // cycle 2
        tick(); start_a = 1'b0;                       // cycle 3
        tick(); tick(); start_a = 1'b1;               // cycle 5
        tick(); start_a = 1'b0;                       // cycle 6
        for (int c = 0; c < 12; c++) tick();
        chk("busy_start_words", 64'(hs_a - hs0), 64'd2);
        chk("busy_start_clr", 64'(clrs_a - clr0), 64'd1);
        chk("busy_start_idle", 64'(busy_a), 64'd0);

        // Async reset mid-transfer
        sign_a = 64'h11111111_22222222;
        q_a.push_back({1'b0, 32'h22222222});
        clr0 = clrs_a;
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        tick(); tick(); tick();                       // cycle 4
        chk("rst_valid_before", 64'(valid_a), 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("rst_valid_drop", 64'(valid_a), 64'd0);
        chk("rst_busy_drop", 64'(busy_a), 64'd0);
        chk("rst_clr_low", 64'(clr_a), 64'd0);
        q_a.delete();
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("rst_no_clr_pulse", 64'(clrs_a - clr0), 64'd0);
        sign_a = 64'h0F0F0F0F_CAFEF00D;
        q_a.push_back({1'b0, 32'hCAFEF00D});
        q_a.push_back({1'b1, 32'h0F0F0F0F});
        hs0 = hs_a;
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        wait_idle_a(20);
        chk("rst_after_words", 64'(hs_a - hs0), 64'd2);
        chk("rst_after_clr", 64'(clrs_a - clr0), 64'd1);
        chk("rst_after_queue", 64'(q_a.size()), 64'd0);
        tick();

        // Single-word configuration
        sign_b = 32'hA5A5A5A5;
        ready_b = 1'b1;
        q_b.push_back({1'b1, 32'hA5A5A5A5});
        start_b = 1'b1;
        tick(); start_b = 1'b0;
        tick(); tick(); tick();                       // cycle 4
        chk("nw1_valid_c4", 64'(valid_b), 64'd1);
        chk("nw1_data_c4", 64'(data_b), 64'hA5A5A5A5);
        chk("nw1_last_c4", 64'(last_b), 64'd1);
        tick();                                       // cycle 5
        chk("nw1_clr_c5", 64'(clr_b), 64'd1);
        chk("nw1_valid_c5", 64'(valid_b), 64'd0);
        tick();                                       // cycle 6
        chk("nw1_done_c6", 64'(done_b), 64'd1);
        tick();                                       // cycle 7
        chk("nw1_busy_c7", 64'(busy_b), 64'd0);
        chk("nw1_words", 64'(hs_b), 64'd1);
        chk("nw1_clr_pulses", 64'(clrs_b), 64'd1);
        chk("nw1_queue_empty", 64'(q_b.size()), 64'd0);

        tick();
        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
